// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receiver and transmitter
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DEFAULT_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    // Clock count at which the middle of the start bit is reached.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - metastability synchronizer and falling-edge detect for the rx pin
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Everything resets to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with mid-bit sampling and a valid/ready byte register
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_en,
    input  logic                  ftdi_rx,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_async(ftdi_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  stop_good;
    logic                  stop_bad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    // LSB arrives first, so shifting in from the top leaves bit i at index i.
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rx_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            idx_d     = '0;
            stop_good = 1'b0;
            stop_bad  = 1'b0;
        end
    end

    always_comb begin
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;

        if (stop_good) begin
            if (!rx_valid_q || rx_ready) begin
                rx_byte_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard testbench for uart_rx_fsm at 16 clocks per bit
module tb_uart_rx_fsm;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = SYNC + 1 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       ftdi_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int fe_cyc = 0;
    int ov_cyc = 0;
    int busy_run = 0;
    int busy_max = 0;
    logic valid_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rise_q[$];

    uart_rx_fsm #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_en    (rx_en),
        .ftdi_rx  (ftdi_rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            got_q.push_back(rx_byte);
            rise_q.push_back(cyc);
        end
        valid_prev <= rx_valid;
        if (frame_err) fe_cyc <= fe_cyc + 1;
        if (overrun) ov_cyc <= ov_cyc + 1;
        busy_run <= busy ? busy_run + 1 : 0;
        if (busy && (busy_run + 1 > busy_max)) busy_max <= busy_run + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        rise_q.delete();
        fe_cyc = 0;
        ov_cyc = 0;
        busy_max = 0;
    endtask

    // Leaves the line at the stop level so a break can be extended by the caller.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        ftdi_rx  = 1'b0;
        fall_cyc = cyc;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            ftdi_rx = b[i];
            wait_cyc(per);
        end
        ftdi_rx = stop_bit;
        wait_cyc(per);
    endtask

    task automatic check_bytes(input string tag);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", tag, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g;
            logic [7:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s_byte: got 0x%02h, expected 0x%02h", tag, g, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_en    = 1'b1;
        ftdi_rx  = 1'b1;
        rx_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rx_byte, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: byte=%h valid=%b fe=%b ov=%b busy=%b, expected all 0",
                     rx_byte, rx_valid, frame_err, overrun, busy);
        end
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(8);
        n_cmp++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_single_byte();
        int lat;
        clear_sb();
        rx_ready = 1'b1;
        exp_q.push_back(8'h47);
        send_frame(8'h47, CPB, 1'b1);
        wait_cyc(20);
        n_cmp++;
        if (rise_q.size() != 1) begin
            n_err++;
            $display("FAIL single_rises: got %0d rx_valid rises, expected 1", rise_q.size());
        end else begin
            lat = rise_q[0] - fall_cyc - 1;
            n_cmp++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                n_err++;
                $display("FAIL single_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
            end
        end
        check_bytes("single");
        n_cmp++;
        if (fe_cyc !== 0 || ov_cyc !== 0 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_flags: fe=%0d ov=%0d valid=%b, expected 0 0 0", fe_cyc, ov_cyc, rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, CPB, 1'b1);
        send_frame(8'h3C, CPB, 1'b1);
        wait_cyc(20);
        check_bytes("b2b");
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_byte !== 8'hA5) begin
            n_err++;
            $display("FAIL b2b_held: valid=%b byte=0x%02h, expected 1 0xa5", rx_valid, rx_byte);
        end
        n_cmp++;
        if (ov_cyc !== 1 || fe_cyc !== 0) begin
            n_err++;
            $display("FAIL b2b_overrun: ov cycles=%0d fe cycles=%0d, expected 1 0", ov_cyc, fe_cyc);
        end
        rx_ready = 1'b1;
        wait_cyc(1);
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_byte !== 8'hA5) begin
            n_err++;
            $display("FAIL b2b_consume: valid=%b byte=0x%02h, expected 0 0xa5", rx_valid, rx_byte);
        end
    endtask

    task automatic test_break();
        clear_sb();
        rx_ready = 1'b1;
        send_frame(8'h55, CPB, 1'b0);
        wait_cyc(40 * CPB);
        n_cmp++;
        if (got_q.size() !== 0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL break_quiet: bytes=%0d busy=%b, expected 0 1", got_q.size(), busy);
        end
        ftdi_rx = 1'b1;
        wait_cyc(2 * CPB);
        exp_q.push_back(8'h12);
        send_frame(8'h12, CPB, 1'b1);
        wait_cyc(20);
        check_bytes("break");
        n_cmp++;
        if (fe_cyc !== 1 || ov_cyc !== 0) begin
            n_err++;
            $display("FAIL break_flags: fe cycles=%0d ov cycles=%0d, expected 1 0", fe_cyc, ov_cyc);
        end
    endtask

    task automatic test_glitch();
        clear_sb();
        ftdi_rx = 1'b0;
        wait_cyc(4);
        ftdi_rx = 1'b1;
        wait_cyc(30);
        n_cmp++;
        if (busy_max < 1 || busy_max > HALF + 1) begin
            n_err++;
            $display("FAIL glitch_busy: busy run %0d cycles, expected 1..%0d", busy_max, HALF + 1);
        end
        n_cmp++;
        if (got_q.size() !== 0 || fe_cyc !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_quiet: bytes=%0d fe=%0d busy=%b, expected 0 0 0", got_q.size(), fe_cyc, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        clear_sb();
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, CPB, 1'b1);
        wait_cyc(20);
        check_bytes("pre_rst");
        partial = 8'h6B;
        ftdi_rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            ftdi_rx = partial[i];
            wait_cyc(CPB);
        end
        ftdi_rx = partial[4];
        wait_cyc(CPB / 2);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rx_byte, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL midrst_outputs: byte=%h valid=%b fe=%b ov=%b busy=%b, expected all 0",
                     rx_byte, rx_valid, frame_err, overrun, busy);
        end
        ftdi_rx = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
        rx_ready = 1'b1;
        clear_sb();
        exp_q.push_back(8'h81);
        send_frame(8'h81, CPB, 1'b1);
        wait_cyc(20);
        check_bytes("post_rst");
        n_cmp++;
        if (fe_cyc !== 0 || ov_cyc !== 0) begin
            n_err++;
            $display("FAIL post_rst_flags: fe=%0d ov=%0d, expected 0 0", fe_cyc, ov_cyc);
        end
    endtask

    task automatic test_skew();
        clear_sb();
        rx_ready = 1'b1;
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, CPB - 1, 1'b1);
        wait_cyc(30);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, CPB + 1, 1'b1);
        wait_cyc(30);
        check_bytes("skew");
        n_cmp++;
        if (fe_cyc !== 0 || ov_cyc !== 0) begin
            n_err++;
            $display("FAIL skew_flags: fe=%0d ov=%0d, expected 0 0", fe_cyc, ov_cyc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_break();
        test_glitch();
        test_reset_mid_frame();
        test_skew();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
